// File: rtl/alu_sequencer_if.sv
// Instruction handshake bundle between the front end and alu_sequencer.
// The front end drives fields and valid; the sequencer returns ready.
interface alu_sequencer_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [2:0]            instr_opcode;
    logic [REG_ADDR_W-1:0] instr_dest;
    logic [REG_ADDR_W-1:0] instr_src1;
    logic [REG_ADDR_W-1:0] instr_src2;
    logic [DATA_W-1:0]     instr_imm;

    modport master (
        output instr_valid, instr_opcode, instr_dest,
        output instr_src1, instr_src2, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_dest,
        input  instr_src1, instr_src2, instr_imm,
        output instr_ready
    );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer owning the register file and driving
// an external sign-magnitude ALU: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
module alu_sequencer #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    alu_sequencer_if.slave    instr,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              instr_done,
    output logic [DATA_W-1:0] disp_value,
    output logic              disp_valid
);
    localparam int NREG = 1 << REG_ADDR_W;

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_ADDI  = 3'd2;
    localparam logic [2:0] OP_SUBI  = 3'd4;
    localparam logic [2:0] OP_CLEAR = 3'd6;
    localparam logic [2:0] OP_DISP  = 3'd7;

    localparam logic [DATA_W-1:0] NEG_ZERO = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            opcode_q, opcode_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [REG_ADDR_W-1:0] src1_q, src1_d;
    logic [REG_ADDR_W-1:0] src2_q, src2_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [DATA_W-1:0]     op_a_q, op_a_d;
    logic [DATA_W-1:0]     op_b_q, op_b_d;
    logic [DATA_W-1:0]     result_q, result_d;
    logic [DATA_W-1:0]     regs_q [NREG];
    logic [DATA_W-1:0]     regs_d [NREG];
    logic [2:0]            alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0]     alu_a_q, alu_a_d;
    logic [DATA_W-1:0]     alu_b_q, alu_b_d;
    logic                  instr_done_q, instr_done_d;
    logic [DATA_W-1:0]     disp_value_q, disp_value_d;
    logic                  disp_valid_q, disp_valid_d;

    logic ready;
    logic uses_imm;
    logic is_clear;
    logic is_disp;

    // Negative zero never reaches a register or the display.
    function automatic logic [DATA_W-1:0] norm(input logic [DATA_W-1:0] v);
        norm = (v == NEG_ZERO) ? '0 : v;
    endfunction

    assign ready    = !rst && (state_q == S_IDLE);
    assign uses_imm = (opcode_q == OP_LOAD) || (opcode_q == OP_ADDI) ||
                      (opcode_q == OP_SUBI);
    assign is_clear = (opcode_q == OP_CLEAR);
    assign is_disp  = (opcode_q == OP_DISP);

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        dest_d       = dest_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        imm_d        = imm_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        regs_d       = regs_q;
        alu_opcode_d = OP_LOAD;
        alu_a_d      = '0;
        alu_b_d      = '0;
        instr_done_d = 1'b0;
        disp_value_d = disp_value_q;
        disp_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (instr.instr_valid && ready) begin
                    opcode_d = instr.instr_opcode;
                    dest_d   = instr.instr_dest;
                    src1_d   = instr.instr_src1;
                    src2_d   = instr.instr_src2;
                    imm_d    = instr.instr_imm;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                op_a_d       = regs_q[src1_q];
                op_b_d       = uses_imm ? imm_q : regs_q[src2_q];
                // ALU inputs are registered so they are stable all of EXECUTE.
                alu_opcode_d = opcode_q;
                alu_a_d      = op_a_d;
                alu_b_d      = op_b_d;
                state_d      = S_EXEC;
            end
            S_EXEC: begin
                unique case (1'b1)
                    (opcode_q == OP_LOAD): result_d = op_b_q;
                    is_disp:               result_d = regs_q[src1_q];
                    is_clear:              result_d = result_q;
                    default:               result_d = alu_result;
                endcase
                instr_done_d = 1'b1;
                state_d      = S_WB;
            end
            S_WB: begin
                unique case (1'b1)
                    is_clear: begin
                        for (int i = 0; i < NREG; i++) regs_d[i] = '0;
                    end
                    is_disp: begin
                        disp_value_d = norm(result_q);
                        disp_valid_d = 1'b1;
                    end
                    default: regs_d[dest_q] = norm(result_q);
                endcase
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            dest_q       <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            imm_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            instr_done_q <= 1'b0;
            disp_value_q <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            dest_q       <= dest_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            imm_q        <= imm_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result_q     <= result_d;
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            instr_done_q <= instr_done_d;
            disp_value_q <= disp_value_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    assign instr.instr_ready = ready;
    assign alu_opcode        = alu_opcode_q;
    assign alu_a             = alu_a_q;
    assign alu_b             = alu_b_q;
    assign instr_done        = instr_done_q;
    assign disp_value        = disp_value_q;
    assign disp_valid        = disp_valid_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer with a behavioural sign-magnitude ALU and a
// display scoreboard fed by the stimulus and drained by a monitor.
module tb_alu_sequencer;
    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_ADDI  = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd5;
    localparam logic [2:0] OP_CLEAR = 3'd6;
    localparam logic [2:0] OP_DISP  = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        instr_done;
    logic [15:0] disp_value;
    logic        disp_valid;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [15:0] disp_q [$];

    alu_sequencer_if #(.DATA_W(16), .REG_ADDR_W(3)) bus ();

    alu_sequencer #(.DATA_W(16), .REG_ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (bus),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .instr_done (instr_done),
        .disp_value (disp_value),
        .disp_valid (disp_valid)
    );

    always #5 clk = ~clk;

    // Ties go to the sign of b, so 5 + (-5) yields negative zero.
    function automatic logic [15:0] sm_add(input logic [15:0] a,
                                           input logic [15:0] b);
        logic [14:0] ma;
        logic [14:0] mb;
        ma = a[14:0];
        mb = b[14:0];
        if (a[15] == b[15]) return {a[15], 15'(ma + mb)};
        if (ma > mb) return {a[15], 15'(ma - mb)};
        return {b[15], 15'(mb - ma)};
    endfunction

    function automatic logic [15:0] sm_alu(input logic [2:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
        logic [29:0] p;
        p = a[14:0] * b[14:0];
        case (op)
            3'd1, 3'd2: return sm_add(a, b);
            3'd3, 3'd4: return sm_add(a, {~b[15], b[14:0]});
            3'd5:       return {a[15] ^ b[15], p[14:0]};
            default:    return 16'h0000;
        endcase
    endfunction

    always_comb alu_result = sm_alu(alu_opcode, alu_a, alu_b);

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (instr_done) done_cnt++;
        if (disp_valid) begin
            if (disp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL disp_unexpected: got %h expected none",
                         disp_value);
            end else begin
                chk("disp_value", disp_value, disp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [2:0] d,
                         input logic [2:0] s1, input logic [2:0] s2,
                         input logic [15:0] imm);
        bus.instr_opcode = op;
        bus.instr_dest   = d;
        bus.instr_src1   = s1;
        bus.instr_src2   = s2;
        bus.instr_imm    = imm;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] d,
                         input logic [2:0] s1, input logic [2:0] s2,
                         input logic [15:0] imm);
        int n;
        n = 0;
        while (!bus.instr_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", bus.instr_ready, 1);
        drive(op, d, s1, s2, imm);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("n1_ready", bus.instr_ready, 0);
        chk("n1_alu_op", alu_opcode, 0);
        @(negedge clk);
        chk("n2_ready", bus.instr_ready, 0);
        chk("n2_alu_op", alu_opcode, op);
        chk("n2_done", instr_done, 0);
        @(negedge clk);
        chk("n3_done", instr_done, 1);
        chk("n3_ready", bus.instr_ready, 0);
        chk("n3_alu_op", alu_opcode, 0);
        @(negedge clk);
        chk("n4_ready", bus.instr_ready, 1);
        chk("n4_done", instr_done, 0);
        exp_done++;
    endtask

    task automatic show(input logic [2:0] r, input logic [15:0] exp);
        disp_q.push_back(exp);
        issue(OP_DISP, 3'd0, r, 3'd0, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        bus.instr_valid = 1'b0;
        drive(OP_LOAD, 3'd0, 3'd0, 3'd0, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", bus.instr_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.instr_ready, 1);
        chk("rst_done", instr_done, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_disp_value", disp_value, 0);
        chk("rst_alu_op", alu_opcode, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);

        issue(OP_LOAD, 3'd1, 3'd0, 3'd0, 16'h0005);
        show(3'd1, 16'h0005);

        issue(OP_LOAD, 3'd2, 3'd0, 3'd0, 16'h8003);
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000);
        issue(OP_SUB, 3'd4, 3'd2, 3'd1, 16'h0000);
        issue(OP_MUL, 3'd5, 3'd1, 3'd2, 16'h0000);
        show(3'd3, 16'h0002);
        show(3'd4, 16'h8008);
        show(3'd5, 16'h800F);

        issue(OP_ADDI, 3'd1, 3'd1, 3'd7, 16'h8005);
        show(3'd1, 16'h0000);
        issue(OP_ADD, 3'd2, 3'd2, 3'd2, 16'h0000);
        show(3'd2, 16'h8006);

        for (int i = 0; i < 8; i++)
            issue(OP_LOAD, 3'(i), 3'd0, 3'd0, 16'(16'h0011 * (i + 1)));
        show(3'd7, 16'h0088);
        snap = done_cnt;
        issue(OP_CLEAR, 3'd3, 3'd1, 3'd2, 16'h1234);
        chk("clear_done_once", done_cnt - snap, 1);
        for (int i = 0; i < 8; i++) show(3'(i), 16'h0000);

        issue(OP_LOAD, 3'd1, 3'd0, 3'd0, 16'h0005);
        issue(OP_LOAD, 3'd2, 3'd0, 3'd0, 16'h0007);
        snap = done_cnt;
        drive(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_done", instr_done, 0);
        chk("rst_mid_ready", bus.instr_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_ready", bus.instr_ready, 1);
        chk("rst_after_alu_op", alu_opcode, 0);
        chk("rst_no_done", done_cnt - snap, 0);
        show(3'd3, 16'h0000);
        show(3'd1, 16'h0000);

        drive(OP_LOAD, 3'd6, 3'd0, 3'd0, 16'h0123);
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(OP_CLEAR, 3'd0, 3'd0, 3'd0, 16'h0000);
        @(negedge clk);
        drive(OP_LOAD, 3'd6, 3'd0, 3'd0, 16'h7FFF);
        @(negedge clk);
        drive(OP_ADD, 3'd6, 3'd6, 3'd6, 16'h0000);
        @(negedge clk);
        chk("held_n4_ready", bus.instr_ready, 1);
        disp_q.push_back(16'h0123);
        drive(OP_DISP, 3'd0, 3'd6, 3'd0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("held_accept_n4", bus.instr_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("held_second_done", instr_done, 1);
        @(negedge clk);
        chk("held_ready_back", bus.instr_ready, 1);
        exp_done += 2;
        show(3'd6, 16'h0123);

        repeat (3) @(negedge clk);
        chk("disp_queue_empty", disp_q.size(), 0);
        chk("done_count", done_cnt, exp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
